// File: rtl/amba3_axi_wr_slave.sv
// AXI3 write-channel slave: accepts one burst at a time, generates FIXED/INCR/WRAP
// beat addresses, drives a synchronous memory write port and returns one B per burst.
module amba3_axi_wr_slave #(
  parameter int TXID_SIZE = 4,
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32
) (
  input  logic                   i_aclk,
  input  logic                   i_areset,
  input  logic [TXID_SIZE-1:0]   i_awid,
  input  logic [ADDR_SIZE-1:0]   i_awaddr,
  input  logic [3:0]             i_awlen,
  input  logic [2:0]             i_awsize,
  input  logic [1:0]             i_awburst,
  input  logic                   i_awvalid,
  output logic                   o_awready,
  input  logic [TXID_SIZE-1:0]   i_wid,
  input  logic [DATA_SIZE-1:0]   i_wdata,
  input  logic [DATA_SIZE/8-1:0] i_wstrb,
  input  logic                   i_wlast,
  input  logic                   i_wvalid,
  output logic                   o_wready,
  output logic [TXID_SIZE-1:0]   o_bid,
  output logic [1:0]             o_bresp,
  output logic                   o_bvalid,
  input  logic                   i_bready,
  output logic                   o_mem_we,
  output logic [ADDR_SIZE-1:0]   o_mem_addr,
  output logic [DATA_SIZE-1:0]   o_mem_wdata,
  output logic [DATA_SIZE/8-1:0] o_mem_wstrb
);

  localparam int STRB_SIZE = DATA_SIZE / 8;
  localparam int SIZE_MAX  = $clog2(STRB_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

  state_t                 r_state;
  state_t                 w_stateNext;
  logic                   r_awready;
  logic                   r_wready;
  logic                   r_bvalid;
  logic [TXID_SIZE-1:0]   r_id;
  logic [ADDR_SIZE-1:0]   r_addr;
  logic [3:0]             r_len;
  logic [2:0]             r_size;
  logic [1:0]             r_burst;
  logic [3:0]             r_beatCnt;
  logic                   r_burstErr;
  logic                   r_err;
  logic [1:0]             r_bresp;
  logic                   r_memWe;
  logic [ADDR_SIZE-1:0]   r_memAddr;
  logic [DATA_SIZE-1:0]   r_memWdata;
  logic [STRB_SIZE-1:0]   r_memWstrb;

  logic                   w_awFire;
  logic                   w_wFire;
  logic                   w_bFire;
  logic                   w_atLen;
  logic                   w_lastBeat;
  logic                   w_beatErr;
  logic                   w_wrapLenOk;
  logic                   w_awBurstErr;
  logic [ADDR_SIZE-1:0]   w_inc;
  logic [ADDR_SIZE-1:0]   w_lenP1;
  logic [ADDR_SIZE-1:0]   w_bound;
  logic [ADDR_SIZE-1:0]   w_addrInc;
  logic [ADDR_SIZE-1:0]   w_addrNext;

  assign w_awFire   = i_awvalid & r_awready;
  assign w_wFire    = i_wvalid & r_wready;
  assign w_bFire    = r_bvalid & i_bready;
  assign w_atLen    = (r_beatCnt == r_len);
  assign w_lastBeat = i_wlast | w_atLen;
  // Early wlast, missing wlast and a foreign wid all flag the response as SLVERR
  assign w_beatErr  = (i_wid != r_id) | (i_wlast != w_atLen);

  assign w_wrapLenOk  = (i_awlen == 4'd1) | (i_awlen == 4'd3) | (i_awlen == 4'd7) | (i_awlen == 4'd15);
  assign w_awBurstErr = (i_awsize > 3'(SIZE_MAX)) | (i_awburst == 2'b11) |
                        ((i_awburst == 2'b10) & ~w_wrapLenOk);

  assign w_inc     = ADDR_SIZE'(1) << r_size;
  assign w_lenP1   = ADDR_SIZE'(r_len) + ADDR_SIZE'(1);
  assign w_bound   = w_lenP1 << r_size;
  assign w_addrInc = r_addr + w_inc;

  always_comb begin
    w_addrNext = r_addr;
    case (r_burst)
      2'b01:   w_addrNext = w_addrInc;
      2'b10:   w_addrNext = (r_addr & ~(w_bound - ADDR_SIZE'(1))) | (w_addrInc & (w_bound - ADDR_SIZE'(1)));
      default: w_addrNext = r_addr;
    endcase
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) r_state <= S_IDLE;
    else          r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:  if (w_awFire) w_stateNext = S_DATA;
      S_DATA:  if (w_wFire && w_lastBeat) w_stateNext = S_RESP;
      S_RESP:  if (w_bFire) w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the upcoming state
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_awready <= (w_stateNext == S_IDLE);
      r_wready  <= (w_stateNext == S_DATA);
      r_bvalid  <= (w_stateNext == S_RESP);
    end
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_id       <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_size     <= '0;
      r_burst    <= '0;
      r_beatCnt  <= '0;
      r_burstErr <= 1'b0;
      r_err      <= 1'b0;
      r_bresp    <= 2'b00;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_memWstrb <= '0;
    end else begin
      r_memWe <= 1'b0;
      if (w_awFire) begin
        r_id       <= i_awid;
        r_addr     <= i_awaddr;
        r_len      <= i_awlen;
        r_size     <= i_awsize;
        r_burst    <= i_awburst;
        r_beatCnt  <= '0;
        r_burstErr <= w_awBurstErr;
        r_err      <= w_awBurstErr;
      end
      if (w_wFire) begin
        r_memWe    <= ~r_burstErr & (i_wid == r_id);
        r_memAddr  <= r_addr;
        r_memWdata <= i_wdata;
        r_memWstrb <= i_wstrb;
        r_addr     <= w_addrNext;
        r_beatCnt  <= r_beatCnt + 4'd1;
        r_err      <= r_err | w_beatErr;
        if (w_lastBeat) r_bresp <= (r_err | w_beatErr) ? 2'b10 : 2'b00;
      end
    end
  end

  assign o_awready   = r_awready;
  assign o_wready    = r_wready;
  assign o_bvalid    = r_bvalid;
  assign o_bid       = r_id;
  assign o_bresp     = r_bresp;
  assign o_mem_we    = r_memWe;
  assign o_mem_addr  = r_memAddr;
  assign o_mem_wdata = r_memWdata;
  assign o_mem_wstrb = r_memWstrb;

endmodule
